// File: rtl/nios_mem_line_fetcher_pkg.sv
// Shared definitions for the line fetcher: FSM state encoding, the fixed
// RAM read latency and a small credit helper used by the issue logic.
package nios_mem_line_fetcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // The on-chip RAM registers the address and drives q combinationally,
  // so a word appears exactly one cycle after its read strobe.
  localparam int MEM_READ_LATENCY = 1;

  // A new read may only be issued while every word already owed to the
  // buffer (stored plus in flight) still leaves a free slot.
  function automatic logic has_credit(input int unsigned occupancy,
                                      input int unsigned depth);
    return (occupancy < depth);
  endfunction

endpackage

// File: rtl/nios_mem_line_fetcher_fifo.sv
// Synchronous FIFO with first-word fall-through output.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset (control only)
//   push_i/data_i  write a word this cycle
//   pop_i          consume the head word this cycle
//   head_o         head-of-buffer word, valid whenever empty_o=0
//   count_o        words currently stored (0..DEPTH)
//   empty_o/full_o occupancy flags
module nios_fetch_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/nios_mem_line_fetcher.sv
// Avalon-MM read master that streams LEN consecutive RAM words starting at
// BASE into a valid/ready output through a small FWFT buffer.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start/base_addr/length  transfer request, sampled only while idle
//   busy, done          transfer in progress / 1-cycle completion pulse
//   mem_grant           arbiter allows a read this cycle
//   mem_chipselect/mem_clken/mem_address  read strobe, clock enable, address
//   mem_readdata        RAM q, valid one cycle after an issued read
//   out_data/out_valid/out_ready  streaming output
module nios_mem_line_fetcher
  import nios_mem_line_fetcher_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 11,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  input  logic              mem_grant,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              inflight_q;
  logic              zlen_done_q, zlen_done_d;

  logic              issue;
  logic              drain_done;
  logic              credit_ok;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_pop;

  // Words owed to the buffer: those stored plus the one still in the RAM.
  assign credit_ok = !fifo_full &&
                     has_credit(int'(fifo_count) + int'(inflight_q),
                                FIFO_DEPTH);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    zlen_done_d = 1'b0;
    issue       = 1'b0;
    drain_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            zlen_done_d = 1'b1;
          end else begin
            state_d     = ST_FETCH;
            addr_d      = base_addr;
            remaining_d = length;
          end
        end
      end
      ST_FETCH: begin
        if (mem_grant && credit_ok) begin
          issue       = 1'b1;
          // Address wraps naturally at the top of the RAM.
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && fifo_empty) begin
          drain_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      zlen_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      // Read latency is one cycle, so the flag lives exactly one cycle and
      // marks the cycle in which mem_readdata must be captured.
      inflight_q  <= issue;
      zlen_done_q <= zlen_done_d;
    end
  end

  assign fifo_pop = out_valid && out_ready;

  nios_fetch_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (inflight_q),
    .data_i  (mem_readdata),
    .pop_i   (fifo_pop),
    .head_o  (out_data),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign mem_chipselect = issue;
  assign mem_clken      = issue;
  assign mem_address    = addr_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = drain_done || zlen_done_q;
  assign out_valid      = !fifo_empty;

endmodule

// File: tb/tb_nios_mem_line_fetcher.sv
module tb_nios_mem_line_fetcher;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 11;
  localparam int DEPTH  = 8;
  localparam int NWORDS = 1024;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic              mem_grant;
  logic              mem_chipselect;
  logic              mem_clken;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  nios_mem_line_fetcher #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .mem_grant      (mem_grant),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_address    (mem_address),
    .mem_readdata   (mem_readdata),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered address, combinational q.
  logic [DATA_W-1:0] ram [NWORDS];
  logic [ADDR_W-1:0] ram_addr_q = '0;
  always @(posedge clk) if (mem_clken) ram_addr_q <= mem_address;
  assign mem_readdata = ram[ram_addr_q];

  // Grant/ready driver. mode 0: held 1, 1: alternate 1,0,.., 2: random, 3: held 0.
  int gmode = 0;
  int rmode = 0;
  bit gtog  = 1'b0;
  int cyc   = 0;
  initial begin
    mem_grant = 1'b1;
    out_ready = 1'b1;
  end
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    case (gmode)
      1:       begin mem_grant = ~gtog; gtog = ~gtog; end
      2:       mem_grant = ($urandom_range(0, 3) != 0);
      3:       mem_grant = 1'b0;
      default: mem_grant = 1'b1;
    endcase
    case (rmode)
      1:       out_ready = ~out_ready;
      2:       out_ready = ($urandom_range(0, 2) != 0);
      3:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: the expected read addresses and output words of the transfer.
  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [DATA_W-1:0] exp_data_q [$];

  int outstanding  = 0;
  int issued_cnt   = 0;
  int popped_cnt   = 0;
  int done_cnt     = 0;
  int last_pop_cyc = 0;
  int done_cyc     = 0;
  bit hold_vld     = 1'b0;
  logic [DATA_W-1:0] hold_data;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      outstanding = 0;
      hold_vld    = 1'b0;
    end else begin
      check("clken==chipselect", {31'b0, mem_clken}, {31'b0, mem_chipselect});
      if (hold_vld && out_valid) check("out_data stable", out_data, hold_data);
      hold_vld = 1'b0;
      if (mem_chipselect) begin
        check("issue needs grant", {31'b0, mem_grant}, 32'd1);
        check("issue within credit", {31'b0, outstanding < DEPTH}, 32'd1);
        if (exp_addr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected issue: address %0h, no read expected", mem_address);
        end else begin
          check("mem_address", {22'b0, mem_address}, {22'b0, exp_addr_q.pop_front()});
        end
        issued_cnt++;
        outstanding++;
      end
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected word: got %0h, no word expected", out_data);
        end else begin
          check("out_data", out_data, exp_data_q.pop_front());
        end
        popped_cnt++;
        outstanding--;
        last_pop_cyc = cyc;
      end else if (out_valid) begin
        hold_vld  = 1'b1;
        hold_data = out_data;
      end
      if (done) begin
        check("done with words pending", exp_data_q.size(), 32'd0);
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic launch(input int base, input int len);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    length    = LEN_W'(len);
    for (int i = 0; i < len; i++) begin
      int a;
      a = (base + i) % NWORDS;
      exp_addr_q.push_back(ADDR_W'(a));
      exp_data_q.push_back(ram[a]);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int bound, input string name);
    int k;
    k = 0;
    while (done_cnt == d0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    check({name, " done seen"}, {31'b0, done_cnt > d0}, 32'd1);
    repeat (3) @(negedge clk);
    check({name, " single done"}, done_cnt - d0, 32'd1);
    check({name, " words left"}, exp_data_q.size(), 32'd0);
    check({name, " reads left"}, exp_addr_q.size(), 32'd0);
    check({name, " idle after"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int d0, i0, p0, k;
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    for (int i = 0; i < NWORDS; i++) ram[i] = $urandom;

    repeat (3) @(negedge clk);
    check("reset busy",       {31'b0, busy},           32'd0);
    check("reset done",       {31'b0, done},           32'd0);
    check("reset chipselect", {31'b0, mem_chipselect}, 32'd0);
    check("reset clken",      {31'b0, mem_clken},      32'd0);
    check("reset out_valid",  {31'b0, out_valid},      32'd0);
    check("reset address",    {22'b0, mem_address},    32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: basic 4-word line with exact cycle timing.
    d0 = done_cnt;
    launch(32'h010, 4);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("t1 chipselect c%0d", c), {31'b0, mem_chipselect}, {31'b0, c <= 4});
      check($sformatf("t1 out_valid c%0d", c),  {31'b0, out_valid},      {31'b0, c >= 3});
    end
    wait_done(d0, 50, "t1");
    check("t1 done after last pop", done_cyc - last_pop_cyc, 32'd1);

    // 2: zero length.
    d0 = done_cnt;
    launch(32'h055, 0);
    @(negedge clk);
    check("t2 done pulse", {31'b0, done}, 32'd1);
    check("t2 busy",       {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("t2 done low",   {31'b0, done}, 32'd0);
    check("t2 done count", done_cnt - d0, 32'd1);

    // 3: address wrap.
    d0 = done_cnt;
    launch(32'h3FE, 4);
    wait_done(d0, 50, "t3");
    check("t3 done after last pop", done_cyc - last_pop_cyc, 32'd1);

    // 4: back-pressure fills the buffer, then drains.
    d0 = done_cnt;
    i0 = issued_cnt;
    rmode = 3;
    launch(32'h100, 20);
    repeat (30) @(negedge clk);
    check("t4 issues while stalled", issued_cnt - i0, 32'd8);
    check("t4 out_valid stalled", {31'b0, out_valid}, 32'd1);
    check("t4 busy stalled",      {31'b0, busy},      32'd1);
    rmode = 0;
    wait_done(d0, 200, "t4");
    check("t4 total issues", issued_cnt - i0, 32'd20);

    // 5: alternating grant.
    d0 = done_cnt;
    gmode = 1;
    launch(32'h200, 6);
    wait_done(d0, 100, "t5");
    gmode = 0;

    // 6: reset in the middle of a transfer, then a clean transfer.
    p0 = popped_cnt;
    launch($urandom_range(0, NWORDS - 1), 16);
    k = 0;
    while (popped_cnt < p0 + 5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t6 five words before reset", {31'b0, popped_cnt >= p0 + 5}, 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("t6 busy cleared",       {31'b0, busy},           32'd0);
    check("t6 done cleared",       {31'b0, done},           32'd0);
    check("t6 chipselect cleared", {31'b0, mem_chipselect}, 32'd0);
    check("t6 clken cleared",      {31'b0, mem_clken},      32'd0);
    check("t6 out_valid cleared",  {31'b0, out_valid},      32'd0);
    check("t6 address cleared",    {22'b0, mem_address},    32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    d0 = done_cnt;
    launch(32'h0A0, 5);
    wait_done(d0, 100, "t6 restart");

    // Randomized transfers with random grant and ready.
    gmode = 2;
    rmode = 2;
    for (int t = 0; t < 8; t++) begin
      d0 = done_cnt;
      launch($urandom_range(0, NWORDS - 1), $urandom_range(1, 40));
      wait_done(d0, 2000, $sformatf("rand%0d", t));
    end
    gmode = 0;
    rmode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
